// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, FSM states, ID_EX / EX_MEM field layout
// and the operand-forwarding and EX_MEM packing helpers.
package exec_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned REG_W      = 4;
  localparam int unsigned CTL_W      = 4;
  localparam int unsigned MUL_CYCLES = 32;
  localparam int unsigned MUL_CNT_W  = $clog2(MUL_CYCLES);

  typedef enum logic [3:0] {
    AluAdd = 4'd0,
    AluSub = 4'd1,
    AluAnd = 4'd2,
    AluOr  = 4'd3,
    AluXor = 4'd4,
    AluSll = 4'd5,
    AluSrl = 4'd6,
    AluMul = 4'd7
  } alu_op_e;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StMulBusy = 2'd1;
  localparam logic [1:0] StMulDone = 2'd2;

  // ID_EX bundle, bit offsets from the LSB
  localparam int unsigned ID_EXTIMM_LSB = 0;
  localparam int unsigned ID_RD_LSB     = 32;
  localparam int unsigned ID_RD2_LSB    = 36;
  localparam int unsigned ID_RB_LSB     = 68;
  localparam int unsigned ID_RD1_LSB    = 72;
  localparam int unsigned ID_RA_LSB     = 104;
  localparam int unsigned ID_ALUCTL_LSB = 108;
  localparam int unsigned ID_MEMTOREG   = 112;
  localparam int unsigned ID_MEMWRITE   = 113;
  localparam int unsigned ID_BRANCH     = 114;
  localparam int unsigned ID_IMMSRC     = 115;

  // EX_MEM bundle: {branchFlag, memWrite, memToReg, Rd, aluResult, storeData}
  localparam int unsigned EXMEM_BITS = 3 + REG_W + 2 * WORD_W;

  // MEM match beats WB match; register 0 is forwardable like any other index.
  function automatic logic [WORD_W-1:0] fwd_sel(
    input logic [REG_W-1:0]  r,
    input logic [WORD_W-1:0] v,
    input logic              mem_we,
    input logic [REG_W-1:0]  mem_rd,
    input logic [WORD_W-1:0] mem_data,
    input logic              wb_we,
    input logic [REG_W-1:0]  wb_rd,
    input logic [WORD_W-1:0] wb_data
  );
    if (mem_we && (mem_rd == r)) begin
      return mem_data;
    end else if (wb_we && (wb_rd == r)) begin
      return wb_data;
    end
    return v;
  endfunction

  function automatic logic [EXMEM_BITS-1:0] pack_exmem(
    input logic [2:0]        ctrl,
    input logic [REG_W-1:0]  rd,
    input logic [WORD_W-1:0] result,
    input logic [WORD_W-1:0] store
  );
    return {ctrl, rd, result, store};
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one partial-product step per enabled cycle, low word of the
// unsigned product. Sequencing of the surrounding pipeline is left to the caller.
module seq_multiplier
  import exec_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] product
);

  logic [WORD_W-1:0]    a_q, b_q, acc_q;
  logic [MUL_CNT_W-1:0] cnt_q;
  logic                 busy_q;
  logic                 last_step;

  assign last_step = busy_q && (cnt_q == MUL_CNT_W'(MUL_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (en) begin
      if (start) begin
        a_q    <= a;
        b_q    <= b;
        acc_q  <= '0;
        cnt_q  <= '0;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        if (b_q[0]) begin
          acc_q <= acc_q + a_q;
        end
        a_q   <= a_q << 1;
        b_q   <= b_q >> 1;
        cnt_q <= cnt_q + MUL_CNT_W'(1);
        if (last_step) begin
          busy_q <= 1'b0;
        end
      end
    end
  end

  assign busy    = busy_q;
  assign done    = last_step;
  assign product = acc_q;

endmodule

// File: rtl/execute_stage.sv
// Execute stage: unpacks ID_EX, selects operands, runs the ALU / iterative multiply and registers
// EX_MEM. Define EX_FORWARD_EN to enable MEM/WB operand forwarding.
module execute_stage
  import exec_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_IDX_W = 4,
  parameter int unsigned BUNDLE_W  = 116,
  parameter int unsigned EXMEM_W   = 71
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [BUNDLE_W-1:0]  idEx,
  input  logic                 fwdMemWE,
  input  logic [REG_IDX_W-1:0] fwdMemRd,
  input  logic [DATA_W-1:0]    fwdMemData,
  input  logic                 fwdWbWE,
  input  logic [REG_IDX_W-1:0] fwdWbRd,
  input  logic [DATA_W-1:0]    fwdWbData,
  output logic                 stall,
  output logic [EXMEM_W-1:0]   exMem
);

  logic [1:0]         state_q, state_d;
  logic [EXMEM_W-1:0] exmem_q, exmem_d;

  logic              imm_src;
  logic [2:0]        ctrl;
  alu_op_e           alu_op;
  logic [REG_W-1:0]  rd;
  logic [WORD_W-1:0] rd1, rd2, ext_imm;
  logic [WORD_W-1:0] op_a, op_b, store_val, alu_res;
  logic              issue_mul, mul_busy, mul_done;
  logic [WORD_W-1:0] mul_product;

  assign imm_src = idEx[ID_IMMSRC];
  assign ctrl    = {idEx[ID_BRANCH], idEx[ID_MEMWRITE], idEx[ID_MEMTOREG]};
  assign alu_op  = alu_op_e'(idEx[ID_ALUCTL_LSB +: CTL_W]);
  assign rd      = idEx[ID_RD_LSB +: REG_W];
  assign rd1     = idEx[ID_RD1_LSB +: WORD_W];
  assign rd2     = idEx[ID_RD2_LSB +: WORD_W];
  assign ext_imm = idEx[ID_EXTIMM_LSB +: WORD_W];

`ifdef EX_FORWARD_EN
  assign op_a      = fwd_sel(idEx[ID_RA_LSB +: REG_W], rd1, fwdMemWE, fwdMemRd, fwdMemData,
                             fwdWbWE, fwdWbRd, fwdWbData);
  assign store_val = fwd_sel(idEx[ID_RB_LSB +: REG_W], rd2, fwdMemWE, fwdMemRd, fwdMemData,
                             fwdWbWE, fwdWbRd, fwdWbData);
`else
  // Without forwarding the hazard unit stalls instead; the forwarding inputs are ignored.
  logic unused_fwd;
  assign unused_fwd = ^{fwdMemWE, fwdMemRd, fwdMemData, fwdWbWE, fwdWbRd, fwdWbData,
                        idEx[ID_RA_LSB +: REG_W], idEx[ID_RB_LSB +: REG_W]};
  assign op_a      = rd1;
  assign store_val = rd2;
`endif

  assign op_b = imm_src ? ext_imm : store_val;

  always_comb begin
    alu_res = op_b;
    case (alu_op)
      AluAdd:  alu_res = op_a + op_b;
      AluSub:  alu_res = op_a - op_b;
      AluAnd:  alu_res = op_a & op_b;
      AluOr:   alu_res = op_a | op_b;
      AluXor:  alu_res = op_a ^ op_b;
      AluSll:  alu_res = op_a << op_b[4:0];
      AluSrl:  alu_res = op_a >> op_b[4:0];
      AluMul:  alu_res = '0;
      default: alu_res = op_b;
    endcase
  end

  assign issue_mul = (state_q == StIdle) && (alu_op == AluMul);

  seq_multiplier u_mul (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .start   (issue_mul),
    .a       (op_a),
    .b       (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Bubbles are all-zero so no memory side effect repeats while the bundle is held upstream.
  always_comb begin
    state_d = state_q;
    exmem_d = exmem_q;
    unique case (state_q)
      StIdle: begin
        if (issue_mul) begin
          state_d = StMulBusy;
          exmem_d = '0;
        end else begin
          exmem_d = pack_exmem(ctrl, rd, alu_res, store_val);
        end
      end
      StMulBusy: begin
        exmem_d = '0;
        if (mul_done) begin
          state_d = StMulDone;
        end
      end
      StMulDone: begin
        exmem_d = pack_exmem(ctrl, rd, mul_product, store_val);
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        exmem_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      exmem_q <= '0;
    end else if (en) begin
      state_q <= state_d;
      exmem_q <= exmem_d;
    end
  end

  assign stall = rst && (issue_mul || mul_busy);
  assign exMem = exmem_q;

endmodule
